muxn_pipe: RTL

Parametrised N-way operand select with a registered, flow-controlled output stage. Picks one of N W-bit inputs, captures it behind a valid/ready handshake, and holds it until the consumer accepts it. It replaces hard-wired 3-input select plus separate pipeline registers at stage boundaries, for example the forwarded operand into EX. Supports back-pressure and flush.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/muxn_pipe_if.sv | 32 +++
 rtl/muxn_sel.sv | 27 ++
 rtl/muxn_pipe.sv | 104 ++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core types: machine width and the EX operand forwarding source
// selector used by the N-way operand select.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2,
    FWD_IMM = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/muxn_pipe_if.sv
// Producer/consumer bundle for muxn_pipe: N-way operand inputs, select,
// flush, and the valid/ready handshake on both sides.
interface muxn_pipe_if
  import riscv_pkg::*;
#(
  parameter int W = XLEN,
  parameter int N = 4
);

  localparam int SW = $clog2(N);

  logic                flush;
  logic [N-1:0][W-1:0] d;
  logic [SW-1:0]       sel;
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        y;
  logic                y_sel_err;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output flush, d, sel, in_valid, out_ready,
    input  in_ready, y, y_sel_err, out_valid
  );

  modport slave (
    input  flush, d, sel, in_valid, out_ready,
    output in_ready, y, y_sel_err, out_valid
  );

endinterface

// File: rtl/muxn_sel.sv
// Combinational N-way select; an out-of-range index falls back to d[0]
// and raises err.
module muxn_sel
  import riscv_pkg::*;
#(
  parameter  int W  = XLEN,
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0][W-1:0] d,
  input  logic [SW-1:0]       sel,
  output logic [W-1:0]        data,
  output logic                err
);

  always_comb begin
    data = d[0];
    err  = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (int'(sel) == i) begin
        data = d[i];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/muxn_pipe.sv
// N-way operand select behind a registered valid/ready output stage.
// Define MUXN_PIPE_SKID_EN for a 2-entry skid with a registered in_ready.
module muxn_pipe
  import riscv_pkg::*;
#(
  parameter int W = XLEN,
  parameter int N = 4
) (
  input logic     clk,
  input logic     rst,
  muxn_pipe_if.slave bus
);

  logic [W-1:0] sel_data;
  logic         sel_err;
  logic         acc;
  logic         emit;
  logic         ov;
  logic [W-1:0] y_q;
  logic         err_q;

  muxn_sel #(.W(W), .N(N)) u_sel (
    .d    (bus.d),
    .sel  (bus.sel),
    .data (sel_data),
    .err  (sel_err)
  );

  assign acc           = bus.in_valid && bus.in_ready;
  assign emit          = ov && bus.out_ready;
  assign bus.out_valid = ov;
  assign bus.y         = y_q;
  assign bus.y_sel_err = err_q;

`ifdef MUXN_PIPE_SKID_EN

  logic         sv;
  logic [W-1:0] sk_d;
  logic         sk_e;

  // Ready depends only on skid occupancy, so no out_ready path reaches it.
  assign bus.in_ready = !sv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov    <= 1'b0;
      sv    <= 1'b0;
      y_q   <= '0;
      err_q <= 1'b0;
      sk_d  <= '0;
      sk_e  <= 1'b0;
    end else if (bus.flush) begin
      ov <= 1'b0;
      sv <= 1'b0;
    end else if (emit && sv) begin
      y_q   <= sk_d;
      err_q <= sk_e;
      sv    <= acc;
      if (acc) begin
        sk_d <= sel_data;
        sk_e <= sel_err;
      end
    end else if (emit) begin
      ov <= acc;
      if (acc) begin
        y_q   <= sel_data;
        err_q <= sel_err;
      end
    end else if (acc) begin
      if (ov) begin
        sk_d <= sel_data;
        sk_e <= sel_err;
        sv   <= 1'b1;
      end else begin
        y_q   <= sel_data;
        err_q <= sel_err;
        ov    <= 1'b1;
      end
    end
  end

`else

  assign bus.in_ready = !ov || bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov    <= 1'b0;
      y_q   <= '0;
      err_q <= 1'b0;
    end else if (bus.flush) begin
      ov <= 1'b0;
    end else if (acc) begin
      ov    <= 1'b1;
      y_q   <= sel_data;
      err_q <= sel_err;
    end else if (emit) begin
      ov <= 1'b0;
    end
  end

`endif

endmodule
